piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_serializer_bit_counter.sv | 33 +++
 rtl/piso_serializer.sv | 71 +++++++
 tb/tb_piso_serializer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared constants for the parallel-in/serial-out serializer: the default word
// width and the two-state FSM encoding.
package piso_pkg;

  localparam int PISO_WIDTH_DEFAULT = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } piso_state_e;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH bit counter. Sync clear beats enable; tc_o flags count WIDTH-1.
module bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with ready/valid load, bit-advance enable
// and frame markers; a word loads back-to-back with the last bit of the previous one.
//
//   state | meaning
//   IDLE  | no word held, sout=0, ready to accept
//   SHIFT | presenting a frame bit on sout, count = index of that bit
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int CW = $clog2(WIDTH);

  piso_state_e      state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             consume;
  logic             accept;

  assign consume   = (state_q == SHIFT) && shift_en;
  // Ready on the last consumed bit lets the next word follow with no gap.
  assign din_ready = reset_n && clear_n && ((state_q == IDLE) || (tc && consume));
  assign accept    = din_valid && din_ready;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (!clear_n || accept),
    .en_i    (consume),
    .cnt_o   (cnt),
    .tc_o    (tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else if (!clear_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else if (accept) begin
      state_q <= SHIFT;
      sreg_q  <= din;
    end else if (consume) begin
      state_q <= tc ? IDLE : SHIFT;
      // Zero fill guarantees the register is empty (sout=0) once the frame ends.
      sreg_q  <= MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  assign sout        = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sout_valid  = (state_q == SHIFT);
  assign frame_start = sout_valid && (cnt == '0);
  assign frame_end   = sout_valid && tc;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: table-driven frames plus hand-written
// clear, async reset and LSB-first sequences.
module tb_piso_serializer;

  typedef struct packed {
    logic       dv;
    logic [7:0] din;
    logic       se;
    logic       cl;
    logic       es;
    logic       ev;
    logic       efs;
    logic       efe;
    logic       er;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       clear_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       shift_en;
  logic       sout;
  logic       sout_valid;
  logic       frame_start;
  logic       frame_end;

  logic [7:0] din_l;
  logic       dv_l;
  logic       rdy_l;
  logic       sout_l;
  logic       valid_l;
  logic       fs_l;
  logic       fe_l;

  int passed = 0;
  int total  = 0;
  vec_t tbl[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_n     (clear_n),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .shift_en    (shift_en),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear_n     (clear_n),
    .din         (din_l),
    .din_valid   (dv_l),
    .din_ready   (rdy_l),
    .shift_en    (shift_en),
    .sout        (sout_l),
    .sout_valid  (valid_l),
    .frame_start (fs_l),
    .frame_end   (fe_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
  endtask

  function automatic vec_t mk(input logic dv, input logic [7:0] d, input logic se,
                              input logic cl, input logic es, input logic ev,
                              input logic efs, input logic efe, input logic er);
    vec_t v;
    v.dv = dv; v.din = d; v.se = se; v.cl = cl;
    v.es = es; v.ev = ev; v.efs = efs; v.efe = efe; v.er = er;
    return v;
  endfunction

  // Drive one cycle's inputs, check that cycle's outputs, then advance one edge.
  task automatic step(input vec_t v, input int idx);
    din_valid = v.dv;
    din       = v.din;
    shift_en  = v.se;
    clear_n   = v.cl;
    #1;
    chk("sout", idx, sout, v.es);
    chk("sout_valid", idx, sout_valid, v.ev);
    chk("frame_start", idx, frame_start, v.efs);
    chk("frame_end", idx, frame_end, v.efe);
    chk("din_ready", idx, din_ready, v.er);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] wa;
    logic [7:0] wb;
    logic [7:0] wf;
    vec_t idle_v;
    wa = 8'hA5;
    wb = 8'h3C;
    wf = 8'hFF;
    idle_v = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    reset_n   = 1'b0;
    clear_n   = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    shift_en  = 1'b1;
    din_l     = 8'h00;
    dv_l      = 1'b0;
    #2;
    chk("rst_din_ready", 0, din_ready, 1'b0);
    chk("rst_sout", 0, sout, 1'b0);
    chk("rst_sout_valid", 0, sout_valid, 1'b0);
    chk("rst_frame_start", 0, frame_start, 1'b0);
    chk("rst_frame_end", 0, frame_end, 1'b0);
    chk("rst_lsb_ready", 0, rdy_l, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single 0xA5 frame
    tbl.push_back(mk(1'b1, wa, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, wa[7-i], 1'b1, i == 0, i == 7, i == 7));
    tbl.push_back(idle_v);
    // back-to-back 0xA5 then 0x3C with din_valid held
    tbl.push_back(mk(1'b1, wa, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, wb, 1'b1, 1'b1, wa[7-i], 1'b1, i == 0, i == 7, i == 7));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, wb[7-i], 1'b1, i == 0, i == 7, i == 7));
    tbl.push_back(idle_v);
    // 0xA5 with a three-cycle stall while bit 3 is presented
    tbl.push_back(mk(1'b1, wa, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, wa[7-i], 1'b1, i == 0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, wa[4], 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 3; i < 8; i++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, wa[7-i], 1'b1, 1'b0, i == 7, i == 7));
    tbl.push_back(idle_v);

    for (int n = 0; n < tbl.size(); n++) step(tbl[n], n + 1);

    // sync clear while bit 5 is presented, with a competing word on din
    step(mk(1'b1, wa, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 100);
    for (int i = 0; i < 5; i++)
      step(mk(1'b0, 8'h00, 1'b1, 1'b1, wa[7-i], 1'b1, i == 0, 1'b0, 1'b0), 101 + i);
    step(mk(1'b1, wf, 1'b1, 1'b0, wa[2], 1'b1, 1'b0, 1'b0, 1'b0), 106);
    step(mk(1'b1, wf, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 107);
    for (int i = 0; i < 8; i++)
      step(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, i == 0, i == 7, i == 7), 108 + i);
    step(idle_v, 116);

    // async reset pulse in the middle of a frame, away from any clock edge
    step(mk(1'b1, wa, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 200);
    for (int i = 0; i < 3; i++)
      step(mk(1'b0, 8'h00, 1'b1, 1'b1, wa[7-i], 1'b1, i == 0, 1'b0, 1'b0), 201 + i);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_sout", 204, sout, 1'b0);
    chk("arst_sout_valid", 204, sout_valid, 1'b0);
    chk("arst_frame_start", 204, frame_start, 1'b0);
    chk("arst_frame_end", 204, frame_end, 1'b0);
    chk("arst_din_ready", 204, din_ready, 1'b0);
    #1;
    reset_n = 1'b1;
    step(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 205);
    step(mk(1'b1, wa, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 206);
    for (int i = 0; i < 8; i++)
      step(mk(1'b0, 8'h00, 1'b1, 1'b1, wa[7-i], 1'b1, i == 0, i == 7, i == 7), 207 + i);
    step(idle_v, 215);

    // LSB-first instance: 0x01 sends a single 1 followed by seven 0s
    dv_l  = 1'b1;
    din_l = 8'h01;
    #1;
    chk("lsb_ready", 300, rdy_l, 1'b1);
    @(posedge clk);
    #1;
    dv_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_sout", 301 + i, sout_l, i == 0);
      chk("lsb_valid", 301 + i, valid_l, 1'b1);
      chk("lsb_frame_start", 301 + i, fs_l, i == 0);
      chk("lsb_frame_end", 301 + i, fe_l, i == 7);
      @(posedge clk);
      #1;
    end
    chk("lsb_idle_valid", 309, valid_l, 1'b0);
    chk("lsb_idle_sout", 309, sout_l, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
